// File: rtl/wb_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl_if
//   Wishbone classic-cycle bus bundle between wb_master_ctrl and a slave.
//
// Parameters:
//   AW - address width
//   DW - data width
//
// Signals (named from the master's point of view):
//   cyc_o  - bus cycle in progress
//   stb_o  - strobe, valid transfer
//   we_o   - 1 = write, 0 = read
//   adr_o  - address
//   dat_o  - write data
//   dat_i  - read data from slave
//   ack_i  - slave acknowledge
//
// Modports: master (wb_master_ctrl side), slave (bus target side).
// -----------------------------------------------------------------------------
interface wb_master_ctrl_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;

    modport master (
        output cyc_o,
        output stb_o,
        output we_o,
        output adr_o,
        output dat_o,
        input  dat_i,
        input  ack_i
    );

    modport slave (
        input  cyc_o,
        input  stb_o,
        input  we_o,
        input  adr_o,
        input  dat_o,
        output dat_i,
        output ack_i
    );
endinterface

// File: rtl/wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl
//   Wishbone classic-cycle initiator. Turns a single-beat core request into one
//   bus cycle, holds CYC/STB until the slave acks, then returns read data and
//   a one-cycle completion pulse. One request at a time; req is only sampled
//   while idle.
//
// Optional feature (macro WBM_TIMEOUT_EN): abort the bus cycle after TIMEOUT
//   consecutive cycles without ack_i, pulsing err together with done.
//   Without the macro there is no counter, err is tied low and TIMEOUT is unused.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low reset
//   req        - request strobe (sampled in IDLE only)
//   req_we     - 1 = write, 0 = read
//   req_adr    - request address
//   req_wdata  - write data
//   busy       - high whenever not idle
//   done       - one-cycle completion pulse
//   err        - one-cycle abort pulse
//   rdata      - last successfully read data
//   wb         - Wishbone bus (master modport)
// -----------------------------------------------------------------------------
module wb_master_ctrl #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                req_we,
    input  logic [AW-1:0]       req_adr,
    input  logic [DW-1:0]       req_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DW-1:0]       rdata,
    wb_master_ctrl_if.master    wb
);

    typedef enum logic [1:0] {StIdle, StBus, StDone, StErr} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic [DW-1:0] r_rdata;
    logic          w_start;
    logic          w_cnt_last;

    assign w_start = (r_state == StIdle) && req;

`ifdef WBM_TIMEOUT_EN
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Counts un-acked BUS cycles; saturates so the compare below stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (w_start) begin
            r_cnt <= 8'd0;
        end else if ((r_state == StBus) && !wb.ack_i && (r_cnt != CntLast)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_cnt_last = (r_cnt == CntLast);
    assign err        = (r_state == StErr);
`else
    assign w_cnt_last = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (req) w_state_next = StBus;
            // ack has priority over a same-edge timeout
            StBus: begin
                if (wb.ack_i) begin
                    w_state_next = StDone;
                end else if (w_cnt_last) begin
                    w_state_next = StErr;
                end
            end
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_we  <= req_we;
                r_adr <= req_adr;
                r_dat <= req_wdata;
            end else if ((r_state == StDone) || (r_state == StErr)) begin
                r_we <= 1'b0;
            end
            if ((r_state == StBus) && wb.ack_i && !r_we) begin
                r_rdata <= wb.dat_i;
            end
        end
    end

    // All outputs are state decodes or registers: no ack_i-to-output path.
    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StDone) || (r_state == StErr);
    assign rdata    = r_rdata;
    assign wb.cyc_o = (r_state == StBus);
    assign wb.stb_o = (r_state == StBus);
    assign wb.we_o  = r_we;
    assign wb.adr_o = r_adr;
    assign wb.dat_o = r_dat;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_master_ctrl
//   Self-checking bench for wb_master_ctrl. A transaction-level model predicts
//   the bus-cycle length, done/err pulses and the read-data register from the
//   number of wait states the slave inserts.
// -----------------------------------------------------------------------------
module tb_wb_master_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
`ifdef WBM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          req       = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_adr   = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;

    int            n_vec     = 0;
    int            n_miss    = 0;
    logic [DW-1:0] exp_rdata = '0;

    wb_master_ctrl_if #(.AW(AW), .DW(DW)) wb ();

    wb_master_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE; slave acks on BUS cycle number wait_n (0-based).
    task automatic do_txn(input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdat,
                          input int wait_n, input string name);
        int k;
        bit exp_to;
        int exp_len;
        exp_to  = TimeoutEn && (wait_n >= int'(TO));
        exp_len = exp_to ? int'(TO) : wait_n + 1;

        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("FAIL %s idle_before: busy=%b required 0", name, busy);
        end
        req       = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_wdata = wdata;
        wb.ack_i  = 1'b0;
        tick();
        // scramble request inputs: the bus must keep the latched values
        req       = 1'b0;
        req_we    = 1'($urandom);
        req_adr   = $urandom;
        req_wdata = $urandom;
        k = 0;
        while ((wb.cyc_o === 1'b1) && (k < 300)) begin
            n_vec++;
            if ({wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, busy, done, err} !==
                {1'b1, we, adr, wdata, 1'b1, 1'b0, 1'b0}) begin
                n_miss++;
                $display("FAIL %s bus_cyc%0d: stb=%b we=%b adr=%h dat=%h busy=%b done=%b err=%b required stb=1 we=%b adr=%h dat=%h busy=1 done=0 err=0",
                         name, k, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, busy, done, err,
                         we, adr, wdata);
            end
            wb.ack_i = (k == wait_n);
            wb.dat_i = (k == wait_n) ? rdat : $urandom;
            tick();
            k++;
        end
        wb.ack_i = 1'b0;
        wb.dat_i = $urandom;
        if (!we && !exp_to) exp_rdata = rdat;

        n_vec++;
        if (k != exp_len) begin
            n_miss++;
            $display("FAIL %s cyc_len: got %0d cycles required %0d", name, k, exp_len);
        end
        n_vec++;
        if ({wb.cyc_o, wb.stb_o, busy, done, err} !== {2'b00, 1'b1, 1'b1, exp_to}) begin
            n_miss++;
            $display("FAIL %s end_pulse: cyc=%b stb=%b busy=%b done=%b err=%b required 0 0 1 1 %b",
                     name, wb.cyc_o, wb.stb_o, busy, done, err, exp_to);
        end
        n_vec++;
        if (rdata !== exp_rdata) begin
            n_miss++;
            $display("FAIL %s rdata: got %h required %h", name, rdata, exp_rdata);
        end
        tick();
        n_vec++;
        if ({busy, done, err, wb.we_o, wb.cyc_o} !== 5'b0 || wb.adr_o !== adr ||
            wb.dat_o !== wdata) begin
            n_miss++;
            $display("FAIL %s back_idle: busy=%b done=%b err=%b we=%b cyc=%b adr=%h dat=%h required 0 0 0 0 0 adr=%h dat=%h",
                     name, busy, done, err, wb.we_o, wb.cyc_o, wb.adr_o, wb.dat_o, adr, wdata);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        repeat (3) tick();
        n_vec++;
        if ({wb.cyc_o, wb.stb_o, wb.we_o, busy, done, err} !== 6'b0 ||
            wb.adr_o !== '0 || wb.dat_o !== '0 || rdata !== '0) begin
            n_miss++;
            $display("FAIL reset_state: cyc=%b stb=%b we=%b busy=%b done=%b err=%b adr=%h dat=%h rdata=%h required all 0",
                     wb.cyc_o, wb.stb_o, wb.we_o, busy, done, err, wb.adr_o, wb.dat_o, rdata);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({wb.cyc_o, busy, done} !== 3'b0) begin
            n_miss++;
            $display("FAIL reset_release: cyc=%b busy=%b done=%b required 0 0 0",
                     wb.cyc_o, busy, done);
        end
    endtask

    task automatic test_read();
        do_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, "read_wait2");
    endtask

    task automatic test_write();
        do_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 0, "write_zero_wait");
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, int'(TO) + 3, "timeout");
    endtask

    task automatic test_race();
        do_txn(1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_0001, int'(TO) - 1, "ack_timeout_race");
    endtask

    task automatic test_spurious_ack();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb.ack_i = 1'b1;
            wb.dat_i = $urandom;
            tick();
            n_vec++;
            if ({busy, done, err, wb.cyc_o} !== 4'b0 || rdata !== exp_rdata) begin
                n_miss++;
                $display("FAIL spurious_ack%0d: busy=%b done=%b err=%b cyc=%b rdata=%h required 0 0 0 0 rdata=%h",
                         i, busy, done, err, wb.cyc_o, rdata, exp_rdata);
            end
        end
        wb.ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  dones;
        int  starts;
        int  cyc;
        bit  prev_cyc;
        bit  prev_busy;
        dones     = 0;
        starts    = 0;
        cyc       = 0;
        prev_cyc  = 1'b0;
        prev_busy = busy;
        req       = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h0000_0080;
        wb.ack_i  = 1'b0;
        while ((dones < 3) && (cyc < 100)) begin
            tick();
            cyc++;
            if (wb.cyc_o && !prev_cyc) begin
                starts++;
                n_vec++;
                if (prev_busy !== 1'b0) begin
                    n_miss++;
                    $display("FAIL b2b_start%0d: previous cycle busy=%b required 0", starts, prev_busy);
                end
            end
            if (done === 1'b1) dones++;
            if (dones == 3) req = 1'b0;
            // single-cycle ack
            wb.ack_i = wb.cyc_o;
            wb.dat_i = $urandom;
            if (wb.cyc_o === 1'b1) exp_rdata = wb.dat_i;
            prev_cyc  = wb.cyc_o;
            prev_busy = busy;
        end
        wb.ack_i = 1'b0;
        tick();
        tick();
        n_vec++;
        if (dones != 3 || starts != 3) begin
            n_miss++;
            $display("FAIL b2b_count: got %0d done pulses %0d starts required 3 3", dones, starts);
        end
        n_vec++;
        if ({wb.cyc_o, busy} !== 2'b0 || rdata !== exp_rdata) begin
            n_miss++;
            $display("FAIL b2b_end: cyc=%b busy=%b rdata=%h required 0 0 rdata=%h",
                     wb.cyc_o, busy, rdata, exp_rdata);
        end
    endtask

    task automatic test_mid_reset();
        req      = 1'b1;
        req_we   = 1'b0;
        req_adr  = 32'h0000_0100;
        wb.ack_i = 1'b0;
        tick();
        req = 1'b0;
        tick();
        n_vec++;
        if (wb.cyc_o !== 1'b1) begin
            n_miss++;
            $display("FAIL midrst_inbus: cyc=%b required 1", wb.cyc_o);
        end
        #2;
        reset = 1'b0;
        exp_rdata = '0;
        #1;
        n_vec++;
        if ({wb.cyc_o, wb.stb_o, busy, done, err} !== 5'b0 || rdata !== '0) begin
            n_miss++;
            $display("FAIL midrst_async: cyc=%b stb=%b busy=%b done=%b err=%b rdata=%h required all 0",
                     wb.cyc_o, wb.stb_o, busy, done, err, rdata);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb.ack_i = 1'b1;
            tick();
            n_vec++;
            if ({wb.cyc_o, busy, done, err} !== 4'b0) begin
                n_miss++;
                $display("FAIL midrst_after%0d: cyc=%b busy=%b done=%b err=%b required 0 0 0 0",
                         i, wb.cyc_o, busy, done, err);
            end
        end
        wb.ack_i = 1'b0;
    endtask

    task automatic test_random();
        int max_wait;
        max_wait = TimeoutEn ? int'(TO) + 2 : 6;
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(max_wait, 0)), $sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 1) begin
                wb.ack_i = 1'($urandom);
                wb.dat_i = $urandom;
                tick();
                wb.ack_i = 1'b0;
            end
        end
    endtask

    initial begin
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        test_reset();
        test_read();
        test_write();
        test_spurious_ack();
        test_back_to_back();
        test_timeout();
        test_race();
        test_random();
        test_mid_reset();
        test_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_master_ctrl.md
Name: wb_master_ctrl

Overview:
- Wishbone classic-cycle initiator (master) that converts single-beat core memory requests into Wishbone bus cycles.
- Sits between the multicycle core's memory-access logic and the Wishbone slave interface.
- Accepts one request at a time, holds CYC/STB until the slave acknowledges, then returns read data and a completion pulse to the core.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum number of cycles in BUS waiting for ack_i before abort; only used with WBM_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  core request strobe; sampled only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_adr  in  AW  request address
- req_wdata  in  DW  write data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle abort pulse; always 0 without WBM_TIMEOUT_EN
- rdata  out  DW  captured read data; holds until the next successful read
- cyc_o  out  1  Wishbone CYC
- stb_o  out  1  Wishbone STB
- we_o  out  1  Wishbone WE
- adr_o  out  AW  Wishbone address
- dat_o  out  DW  Wishbone write data
- dat_i  in  DW  Wishbone read data
- ack_i  in  1  Wishbone ACK

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - cyc_o, stb_o, we_o, busy, done, err = 0.
  - adr_o, dat_o, rdata = 0.
  - Timeout counter = 0.
  - Reset asserted mid-cycle drops cyc_o/stb_o immediately, with no done or err pulse.
- States: IDLE, BUS, DONE, ERR. All outputs are registered or decoded from state only; no combinational path from ack_i to any output.
- IDLE:
  - On a posedge with req=1: latch req_adr→adr_o, req_wdata→dat_o, req_we→we_o; go to BUS.
  - cyc_o=stb_o=1 from the next cycle, so there is 1 cycle of latency from req to bus assertion.
  - req=0: stay in IDLE.
- BUS:
  - cyc_o=stb_o=1; adr_o, dat_o, we_o held stable for the whole cycle.
  - Posedge with ack_i=1: if we_o=0, capture dat_i→rdata; go to DONE.
  - Posedge with ack_i=0: stay in BUS and increment the counter.
- DONE:
  - cyc_o=stb_o=0; done=1 for exactly this cycle; go to IDLE unconditionally.
  - req is ignored in DONE and BUS: no queuing, and the core must re-present req in IDLE.
  - Minimum request-to-request spacing is 3 cycles (IDLE→BUS→DONE).
- ERR:
  - cyc_o=stb_o=0; err=1 and done=1 for exactly this cycle; rdata unchanged; go to IDLE.
- Counter:
  - Cleared on entry to BUS.
  - Saturates at TIMEOUT−1.
  - Compiled out entirely without WBM_TIMEOUT_EN.
- Simultaneous events:
  - ack_i=1 on the same posedge the counter reaches TIMEOUT−1: ack wins, go to DONE, err=0.
- Spurious bus activity:
  - ack_i in IDLE, DONE or ERR is ignored; rdata is not modified.
- Slave insertion of any number of wait states is tolerated; stb_o is held until ack_i is sampled.
- we_o is returned to 0 when entering IDLE. adr_o and dat_o keep their last value.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- Defined:
  - BUS exits to ERR after TIMEOUT consecutive posedges without ack_i; counter value TIMEOUT−1 with ack_i=0 triggers the exit.
  - The ERR state and the err pulse are live.
- Undefined:
  - No counter and no ERR state; BUS waits indefinitely for ack_i.
  - err is tied to 0; the TIMEOUT parameter is unused.

Test Plan:
- Reset then read: reset low 3 cycles; req=1, req_we=0, req_adr=0x0000_0010 in IDLE; slave acks 2 cycles after stb_o with dat_i=0xDEAD_BEEF.
  - Required: cyc_o/stb_o high for 3 cycles; rdata=0xDEAD_BEEF; single done pulse; busy low 1 cycle after done.
- Write with zero wait: req_we=1, req_adr=0x20, req_wdata=0x1234_5678; ack_i high on the first BUS cycle.
  - Required: we_o=1 and dat_o=0x1234_5678 while stb_o=1; cyc_o high exactly 1 cycle; rdata unchanged.
- Back-to-back requests: req held high continuously for 3 transactions with single-cycle acks.
  - Required: each transaction starts only from IDLE; cyc_o low ≥1 cycle between transactions; exactly 3 done pulses.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT=4): read with no ack_i.
  - Required: stb_o high 4 cycles; err=done=1 for 1 cycle; rdata unchanged.
- Same-edge race (WBM_TIMEOUT_EN, TIMEOUT=4): ack_i=1 on the 4th BUS cycle.
  - Required: done=1, err=0, rdata=dat_i.
- Reset mid-cycle: assert reset while in BUS.
  - Required: cyc_o/stb_o drop before the next edge; no done/err pulse; busy=0.
